// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: axis phase encoding and
// the phase-to-phase sequencing rule used by each axis.
package video_timing_pkg;

  localparam int DEFAULT_W = 10;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } phase_e;

  // Zero-length porches are skipped; SYNC and ACTIVE are never skipped.
  function automatic phase_e next_phase(input phase_e cur,
                                        input logic   back_zero,
                                        input logic   front_zero);
    phase_e nxt;
    case (cur)
      SYNC:    nxt = back_zero ? ACTIVE : BACK;
      BACK:    nxt = ACTIVE;
      ACTIVE:  nxt = front_zero ? SYNC : FRONT;
      default: nxt = SYNC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One timing axis: walks SYNC -> BACK -> ACTIVE -> FRONT, one count per step,
// and flags the final count of the last non-skipped phase.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step_i,
  input  logic [W-1:0] len_sync_i,
  input  logic [W-1:0] len_back_i,
  input  logic [W-1:0] len_active_i,
  input  logic [W-1:0] len_front_i,
  output phase_e       phase_o,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  phase_e       phase_q, phase_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] cur_len;
  logic         cur_last;

  always_comb begin
    cur_len = len_front_i;
    case (phase_q)
      SYNC:    cur_len = (len_sync_i == '0) ? W'(1) : len_sync_i;
      BACK:    cur_len = len_back_i;
      ACTIVE:  cur_len = (len_active_i == '0) ? W'(1) : len_active_i;
      default: cur_len = len_front_i;
    endcase

    // A zero-length porch can only be current if lengths changed under us;
    // treat it as already finished so the axis never stalls.
    cur_last = (cur_len == '0) || (count_q == cur_len - W'(1));
    last_o   = cur_last &&
               ((phase_q == FRONT) || ((phase_q == ACTIVE) && (len_front_i == '0)));

    phase_d = phase_q;
    count_d = count_q;
    if (step_i) begin
      if (cur_last) begin
        phase_d = next_phase(phase_q, len_back_i == '0, len_front_i == '0);
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= SYNC;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase_o = phase_q;
  assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: horizontal and vertical axis
// sequencers, per-frame shadowed configuration, registered outputs + delay.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int DE_DELAY = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         PixelEn,
  input  logic [W-1:0] HSynchPulse,
  input  logic [W-1:0] HBackPorch,
  input  logic [W-1:0] HActiveVideo,
  input  logic [W-1:0] HFrontPorch,
  input  logic [W-1:0] VSynchPulse,
  input  logic [W-1:0] VBackPorch,
  input  logic [W-1:0] VActiveVideo,
  input  logic [W-1:0] VFrontPorch,
  input  logic         HPolarity,
  input  logic         VPolarity,
  output logic         hsync,
  output logic         vsync,
  output logic         active,
  output logic [W-1:0] xposition,
  output logic [W-1:0] yposition,
  output logic         LineEnd,
  output logic         FrameEnd
);

  localparam int CW = 2 * W + 3;

  // load_q is set by reset and clears on the first edge after release, so the
  // axes run from the live inputs until the shadow copy has been taken.
  logic         load_q;
  logic [W-1:0] hs_sh_q, hb_sh_q, ha_sh_q, hf_sh_q;
  logic [W-1:0] vs_sh_q, vb_sh_q, va_sh_q, vf_sh_q;
  logic         hpol_sh_q, vpol_sh_q;

  logic [W-1:0] hs_len, hb_len, ha_len, hf_len;
  logic [W-1:0] vs_len, vb_len, va_len, vf_len;
  logic         hpol_eff, vpol_eff;

  assign hs_len   = load_q ? HSynchPulse  : hs_sh_q;
  assign hb_len   = load_q ? HBackPorch   : hb_sh_q;
  assign ha_len   = load_q ? HActiveVideo : ha_sh_q;
  assign hf_len   = load_q ? HFrontPorch  : hf_sh_q;
  assign vs_len   = load_q ? VSynchPulse  : vs_sh_q;
  assign vb_len   = load_q ? VBackPorch   : vb_sh_q;
  assign va_len   = load_q ? VActiveVideo : va_sh_q;
  assign vf_len   = load_q ? VFrontPorch  : vf_sh_q;
  assign hpol_eff = load_q ? HPolarity    : hpol_sh_q;
  assign vpol_eff = load_q ? VPolarity    : vpol_sh_q;

  phase_e       h_phase, v_phase;
  logic [W-1:0] h_count, v_count;
  logic         h_last, v_last;
  logic         line_end, frame_end;

  assign line_end  = PixelEn & h_last;
  assign frame_end = line_end & v_last;

  timing_axis #(.W(W)) u_haxis (
    .clock        (clock),
    .reset        (reset),
    .step_i       (PixelEn),
    .len_sync_i   (hs_len),
    .len_back_i   (hb_len),
    .len_active_i (ha_len),
    .len_front_i  (hf_len),
    .phase_o      (h_phase),
    .count_o      (h_count),
    .last_o       (h_last)
  );

  timing_axis #(.W(W)) u_vaxis (
    .clock        (clock),
    .reset        (reset),
    .step_i       (line_end),
    .len_sync_i   (vs_len),
    .len_back_i   (vb_len),
    .len_active_i (va_len),
    .len_front_i  (vf_len),
    .phase_o      (v_phase),
    .count_o      (v_count),
    .last_o       (v_last)
  );

  always_ff @(posedge clock) begin
    if (load_q || frame_end) begin
      hs_sh_q   <= HSynchPulse;
      hb_sh_q   <= HBackPorch;
      ha_sh_q   <= HActiveVideo;
      hf_sh_q   <= HFrontPorch;
      vs_sh_q   <= VSynchPulse;
      vb_sh_q   <= VBackPorch;
      va_sh_q   <= VActiveVideo;
      vf_sh_q   <= VFrontPorch;
      hpol_sh_q <= HPolarity;
      vpol_sh_q <= VPolarity;
    end
  end

  // Stage 0 captures the decode of the pixel consumed on each enabled edge.
  logic [W-1:0] x_d, y_d;
  logic [CW-1:0] ctl_d;
  logic          hsf_d, vsf_d;

  logic [CW-1:0] ctl_q [DE_DELAY+1];
  logic          hsf_q [DE_DELAY+1];
  logic          vsf_q [DE_DELAY+1];
  logic          vld_q [DE_DELAY+1];
  logic [1:0]    pol_q [DE_DELAY+1];

  assign x_d = (h_phase == ACTIVE) ? h_count : '0;
  assign y_d = (v_phase == ACTIVE) ? v_count : '0;

  always_comb begin
    ctl_d = {ctl_q[0][CW-1:2], 2'b00};
    hsf_d = hsf_q[0];
    vsf_d = vsf_q[0];
    if (PixelEn) begin
      ctl_d = {(h_phase == ACTIVE) && (v_phase == ACTIVE), x_d, y_d,
               h_last, h_last & v_last};
      hsf_d = (h_phase == SYNC);
      vsf_d = (v_phase == SYNC);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_q <= 1'b1;
      for (int i = 0; i <= DE_DELAY; i++) begin
        ctl_q[i] <= '0;
        hsf_q[i] <= 1'b1;
        vsf_q[i] <= 1'b1;
        vld_q[i] <= 1'b0;
      end
    end else begin
      load_q   <= 1'b0;
      ctl_q[0] <= ctl_d;
      hsf_q[0] <= hsf_d;
      vsf_q[0] <= vsf_d;
      vld_q[0] <= 1'b1;
      for (int i = 1; i <= DE_DELAY; i++) begin
        ctl_q[i] <= ctl_q[i-1];
        hsf_q[i] <= hsf_q[i-1];
        vsf_q[i] <= vsf_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Polarity rides alongside the sync flags; until a stage is valid the
  // output falls back to the live effective polarity.
  always_ff @(posedge clock) begin
    if (PixelEn || !vld_q[0]) pol_q[0] <= {hpol_eff, vpol_eff};
    for (int i = 1; i <= DE_DELAY; i++) pol_q[i] <= pol_q[i-1];
  end

  logic hpol_o, vpol_o;
  assign hpol_o = vld_q[DE_DELAY] ? pol_q[DE_DELAY][1] : hpol_eff;
  assign vpol_o = vld_q[DE_DELAY] ? pol_q[DE_DELAY][0] : vpol_eff;

  assign hsync     = hsf_q[DE_DELAY] ? hpol_o : ~hpol_o;
  assign vsync     = vsf_q[DE_DELAY] ? vpol_o : ~vpol_o;
  assign active    = ctl_q[DE_DELAY][CW-1];
  assign xposition = ctl_q[DE_DELAY][CW-2 -: W];
  assign yposition = ctl_q[DE_DELAY][W+1 -: W];
  assign LineEnd   = ctl_q[DE_DELAY][1];
  assign FrameEnd  = ctl_q[DE_DELAY][0];

endmodule
